// File: rtl/uart_bridge_ctl.sv
// uart_bridge_ctl
// Clocked FTDI channel-B <-> ESP8266 UART bridge. Both serial lines pass
// through metastability synchronisers and an output register. Each direction
// has a retriggerable activity-LED stretcher. A break-triggered sequencer
// (a long low on the host line) resets the ESP8266 and straps GPIO0 into
// flash-run or bootloader mode.
//
// Optional build macro: UART_BRIDGE_LOOPBACK_EN
//   Adds a `loopback` input. While its synchronised value is 1, the host line
//   is echoed back on host_txd, the ESP8266 is isolated (esp_txd held idle,
//   esp_rxd ignored), and led_rx follows host-side edges. Break detection
//   keeps running.

module uart_bridge_ctl #(
    parameter int unsigned SYNC_STAGES  = 2,        // 2..4
    parameter int unsigned LED_STRETCH  = 600000,   // LED on-time after last falling edge
    parameter int unsigned BREAK_CYCLES = 1200000,  // continuous low that counts as break
    parameter int unsigned RESET_HOLD   = 120000,   // esp_reset_n low after break ends
    parameter int unsigned STRAP_CYCLES = 1200000   // GPIO0 strap held after reset release
) (
    input  logic clk,
    input  logic rst,
    input  logic host_rxd,
    output logic host_txd,
    output logic esp_txd,
    input  logic esp_rxd,
    output logic esp_reset_n,
    output logic esp_gpio0,
    input  logic boot_sel,
`ifdef UART_BRIDGE_LOOPBACK_EN
    input  logic loopback,
`endif
    output logic led_tx,
    output logic led_rx,
    output logic led_rst
);

    // ------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------
    localparam int unsigned LED_W   = $clog2(LED_STRETCH + 1);
    localparam int unsigned BRK_W   = $clog2(BREAK_CYCLES + 1);
    localparam int unsigned TMR_MAX = (RESET_HOLD > STRAP_CYCLES) ? RESET_HOLD : STRAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [LED_W-1:0] LED_LOAD   = LED_W'(LED_STRETCH);
    localparam logic [BRK_W-1:0] BRK_LAST   = BRK_W'(BREAK_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RESET_HOLD - 1);
    localparam logic [TMR_W-1:0] STRAP_LAST = TMR_W'(STRAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StHold,
        StStrap
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] h_sync_q;
    logic [SYNC_STAGES-1:0] e_sync_q;
    logic                   h_s;
    logic                   e_s;

    // Shift both serial inputs through their synchroniser chains; idle = 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_q <= '1;
            e_sync_q <= '1;
        end else begin
            h_sync_q <= {h_sync_q[SYNC_STAGES-2:0], host_rxd};
            e_sync_q <= {e_sync_q[SYNC_STAGES-2:0], esp_rxd};
        end
    end

    assign h_s = h_sync_q[SYNC_STAGES-1];
    assign e_s = e_sync_q[SYNC_STAGES-1];

    logic lb_s;

`ifdef UART_BRIDGE_LOOPBACK_EN
    logic [SYNC_STAGES-1:0] l_sync_q;

    // Synchronise the loopback request; resets to normal bridging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_sync_q <= '0;
        end else begin
            l_sync_q <= {l_sync_q[SYNC_STAGES-2:0], loopback};
        end
    end

    assign lb_s = l_sync_q[SYNC_STAGES-1];
`else
    assign lb_s = 1'b0;
`endif

    // In loopback the receive-side LED watches the host line instead.
    logic rx_src;
    assign rx_src = lb_s ? h_s : e_s;

    // ------------------------------------------------------------------
    // Activity stretchers
    // ------------------------------------------------------------------
    logic             h_prev_q;
    logic             rx_prev_q;
    logic             h_fall;
    logic             rx_fall;
    logic [LED_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [LED_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             led_tx_q;
    logic             led_rx_q;

    assign h_fall  = h_prev_q & ~h_s;
    assign rx_fall = rx_prev_q & ~rx_src;

    // Reload on a falling edge (retrigger), else count down and stick at 0.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (h_fall) begin
            tx_cnt_d = LED_LOAD;
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end
        if (rx_fall) begin
            rx_cnt_d = LED_LOAD;
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end
    end

    // Edge-history flops, stretch counters and registered LED drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_prev_q  <= 1'b1;
            rx_prev_q <= 1'b1;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            led_tx_q  <= 1'b0;
            led_rx_q  <= 1'b0;
        end else begin
            h_prev_q  <= h_s;
            rx_prev_q <= rx_src;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            // LED rises on the same edge that loads the counter.
            led_tx_q  <= (tx_cnt_d != '0);
            led_rx_q  <= (rx_cnt_d != '0);
        end
    end

    // ------------------------------------------------------------------
    // Break-triggered reset / boot-strap sequencer
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             mode_q, mode_d;   // 1 = bootloader requested
    logic             seq_active_d;

    // Next-state logic: detect a long low, hold reset, then hold the strap.
    always_comb begin
        state_d   = state_q;
        brk_cnt_d = brk_cnt_q;
        tmr_d     = tmr_q;
        mode_d    = mode_q;
        unique case (state_q)
            StIdle: begin
                if (h_s) begin
                    brk_cnt_d = '0;
                end else begin
                    state_d   = StBreak;
                    brk_cnt_d = BRK_W'(1);
                end
            end
            StBreak: begin
                if (h_s) begin
                    // Ordinary start/data bit: abandon quietly.
                    state_d   = StIdle;
                    brk_cnt_d = '0;
                end else if (brk_cnt_q >= BRK_LAST) begin
                    state_d   = StHold;
                    brk_cnt_d = '0;
                    tmr_d     = '0;
                    mode_d    = boot_sel;
                end else begin
                    brk_cnt_d = brk_cnt_q + 1'b1;
                end
            end
            StHold: begin
                // Reset-hold time only starts once the break has ended.
                if (!h_s) begin
                    tmr_d = '0;
                end else if (tmr_q >= HOLD_LAST) begin
                    state_d = StStrap;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StStrap: begin
                // Line activity is ignored until the strap window closes.
                if (tmr_q >= STRAP_LAST) begin
                    state_d = StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                brk_cnt_d = '0;
                tmr_d     = '0;
            end
        endcase
    end

    assign seq_active_d = (state_d == StHold) || (state_d == StStrap);

    // Sequencer state, counters and latched boot mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            brk_cnt_q <= '0;
            tmr_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            brk_cnt_q <= brk_cnt_d;
            tmr_q     <= tmr_d;
            mode_q    <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic host_txd_q;
    logic esp_txd_q;
    logic esp_reset_n_q;
    logic esp_gpio0_q;
    logic led_rst_q;

    // Forwarding and sequencer outputs, decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_txd_q    <= 1'b1;
            esp_txd_q     <= 1'b1;
            esp_reset_n_q <= 1'b1;
            esp_gpio0_q   <= 1'b1;
            led_rst_q     <= 1'b0;
        end else begin
            host_txd_q    <= lb_s ? h_s : e_s;
            // Keep the ESP RX line idle while it is in reset or strapping.
            esp_txd_q     <= (seq_active_d || lb_s) ? 1'b1 : h_s;
            esp_reset_n_q <= (state_d != StHold);
            esp_gpio0_q   <= seq_active_d ? ~mode_d : 1'b1;
            led_rst_q     <= seq_active_d;
        end
    end

    assign host_txd    = host_txd_q;
    assign esp_txd     = esp_txd_q;
    assign esp_reset_n = esp_reset_n_q;
    assign esp_gpio0   = esp_gpio0_q;
    assign led_tx      = led_tx_q;
    assign led_rx      = led_rx_q;
    assign led_rst     = led_rst_q;

endmodule

// File: tb/tb_uart_bridge_ctl.sv
// Self-checking bench for uart_bridge_ctl. A behavioural model (delay-line
// queues, last-edge timestamps and low/high run-lengths) predicts every output
// each cycle; scenario tasks add explicit timing checks on top.
`timescale 1ns/1ps

module tb_uart_bridge_ctl;

    localparam int SYNC  = 2;
    localparam int LED   = 8;
    localparam int BRK   = 20;
    localparam int HOLD  = 5;
    localparam int STRAP = 10;

    localparam int PH_WATCH = 0;
    localparam int PH_HOLD  = 1;
    localparam int PH_STRAP = 2;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic host_rxd = 1'b1;
    logic esp_rxd  = 1'b1;
    logic boot_sel = 1'b0;
    logic host_txd, esp_txd, esp_reset_n, esp_gpio0, led_tx, led_rx, led_rst;
`ifdef UART_BRIDGE_LOOPBACK_EN
    logic loopback = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    bit         h_q[$];
    bit         e_q[$];
    int         cyc, last_hf, last_ef, phase, low_run, high_run, strap_n;
    bit         hs_prev, es_prev, mode;
    logic [6:0] exp_v;

    always #5 clk = ~clk;

    uart_bridge_ctl #(
        .SYNC_STAGES (SYNC),
        .LED_STRETCH (LED),
        .BREAK_CYCLES(BRK),
        .RESET_HOLD  (HOLD),
        .STRAP_CYCLES(STRAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_rxd   (host_rxd),
        .host_txd   (host_txd),
        .esp_txd    (esp_txd),
        .esp_rxd    (esp_rxd),
        .esp_reset_n(esp_reset_n),
        .esp_gpio0  (esp_gpio0),
        .boot_sel   (boot_sel),
`ifdef UART_BRIDGE_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .led_tx     (led_tx),
        .led_rx     (led_rx),
        .led_rst    (led_rst)
    );

    // {host_txd, esp_txd, esp_reset_n, esp_gpio0, led_tx, led_rx, led_rst}
    function automatic logic [6:0] dut_vec();
        return {host_txd, esp_txd, esp_reset_n, esp_gpio0, led_tx, led_rx, led_rst};
    endfunction

    task automatic model_reset();
        h_q.delete();
        e_q.delete();
        for (int i = 0; i < SYNC; i++) begin
            h_q.push_back(1'b1);
            e_q.push_back(1'b1);
        end
        cyc      = 0;
        last_hf  = -1000;
        last_ef  = -1000;
        phase    = PH_WATCH;
        low_run  = 0;
        high_run = 0;
        strap_n  = 0;
        hs_prev  = 1'b1;
        es_prev  = 1'b1;
        mode     = 1'b0;
        exp_v    = 7'b1111000;
    endtask

    // One clock edge of the reference: lines seen SYNC edges late, LEDs lit
    // for LED cycles after the latest fall, sequencer driven by run-lengths.
    task automatic model_step();
        bit hs, es;
        cyc++;
        hs = h_q[0];
        es = e_q[0];
        h_q.delete(0);
        e_q.delete(0);
        h_q.push_back(host_rxd);
        e_q.push_back(esp_rxd);
        if (hs_prev && !hs) last_hf = cyc;
        if (es_prev && !es) last_ef = cyc;
        hs_prev = hs;
        es_prev = es;
        case (phase)
            PH_WATCH: begin
                low_run = hs ? 0 : low_run + 1;
                if (low_run == BRK) begin
                    phase    = PH_HOLD;
                    mode     = boot_sel;
                    high_run = 0;
                    low_run  = 0;
                end
            end
            PH_HOLD: begin
                high_run = hs ? high_run + 1 : 0;
                if (high_run == HOLD) begin
                    phase   = PH_STRAP;
                    strap_n = 0;
                end
            end
            default: begin
                strap_n++;
                if (strap_n == STRAP) begin
                    phase   = PH_WATCH;
                    low_run = 0;
                end
            end
        endcase
        exp_v = {es,
                 (phase != PH_WATCH) ? 1'b1 : hs,
                 phase != PH_HOLD,
                 (phase == PH_WATCH) ? 1'b1 : ~mode,
                 (cyc - last_hf) < LED,
                 (cyc - last_ef) < LED,
                 phase != PH_WATCH};
    endtask

    // Inputs change at negedge; the model samples them at the posedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        host_rxd = 1'b1;
        esp_rxd  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        host_rxd = 1'b0;
        esp_rxd  = 1'b0;
        boot_sel = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== 7'b1111000)
            $display("FAIL reset_values got %b exp %b", dut_vec(), 7'b1111000);
        else n_pass++;
        boot_sel = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL reset_idle cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_forward();
        int fall_at = -1;
        int led_hi  = 0;
        int host_bad = 0;
        do_reset();
        host_rxd = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL forward cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
            if (fall_at < 0 && esp_txd === 1'b0) fall_at = i;
            if (led_tx === 1'b1) led_hi++;
            if (host_txd !== 1'b1) host_bad++;
        end
        n_checks++;
        if (fall_at != SYNC + 1)
            $display("FAIL forward_latency got %0d exp %0d", fall_at, SYNC + 1);
        else n_pass++;
        n_checks++;
        if (led_hi != LED) $display("FAIL led_tx_width got %0d exp %0d", led_hi, LED);
        else n_pass++;
        n_checks++;
        if (host_bad != 0) $display("FAIL host_txd_idle got %0d bad exp 0", host_bad);
        else n_pass++;
        host_rxd = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_led_retrigger();
        int first = -1;
        int last  = -1;
        int hi    = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            // Two falling edges 5 cycles apart.
            esp_rxd = !(i == 0 || i == 1 || i == 5 || i == 6);
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL led_retrigger cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
            if (led_rx === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                hi++;
            end
        end
        n_checks++;
        if (hi != 5 + LED) $display("FAIL led_rx_total got %0d exp %0d", hi, 5 + LED);
        else n_pass++;
        n_checks++;
        if (last - first + 1 != hi)
            $display("FAIL led_rx_gap got span %0d exp %0d", last - first + 1, hi);
        else n_pass++;
    endtask

    task automatic test_short_break();
        int rst_lo = 0;
        int seq_hi = 0;
        int tx_lo  = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            host_rxd = (i >= BRK - 1);
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL short_break cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
            if (esp_reset_n !== 1'b1) rst_lo++;
            if (led_rst !== 1'b0) seq_hi++;
            if (esp_txd === 1'b0) tx_lo++;
        end
        n_checks++;
        if (rst_lo != 0 || seq_hi != 0)
            $display("FAIL short_break_seq got rst_lo %0d led_rst %0d exp 0 0", rst_lo, seq_hi);
        else n_pass++;
        n_checks++;
        if (tx_lo != BRK - 1) $display("FAIL short_break_txd got %0d exp %0d", tx_lo, BRK - 1);
        else n_pass++;
    endtask

    task automatic test_boot(input bit bsel, input bit pulse);
        int hold_at = -1;
        int rst_lo  = 0;
        int gp_lo   = 0;
        int seq_hi  = 0;
        do_reset();
        boot_sel = bsel;
        for (int i = 0; i < 70; i++) begin
            // 30-cycle break; optional short low burst inside the strap window.
            host_rxd = (i >= 30) && !(pulse && i >= 38 && i <= 40);
            if (i >= 22 && i <= 50) boot_sel = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL boot%0d cyc %0d got %b exp %b", bsel, i, dut_vec(), exp_v);
            else n_pass++;
            if (esp_reset_n === 1'b0) begin
                rst_lo++;
                if (hold_at < 0) begin
                    hold_at = i;
                    n_checks++;
                    if ({esp_gpio0, esp_txd, led_rst} !== {~bsel, 1'b1, 1'b1})
                        $display("FAIL hold_entry got %b exp %b",
                                 {esp_gpio0, esp_txd, led_rst}, {~bsel, 1'b1, 1'b1});
                    else n_pass++;
                end
            end
            if (esp_gpio0 === 1'b0) gp_lo++;
            if (led_rst === 1'b1) seq_hi++;
        end
        boot_sel = 1'b0;
        // Break counted from the first synced-low edge (SYNC edges after drive).
        n_checks++;
        if (hold_at != SYNC + BRK - 1)
            $display("FAIL hold_time got %0d exp %0d", hold_at, SYNC + BRK - 1);
        else n_pass++;
        n_checks++;
        if (rst_lo != (30 - BRK) + HOLD)
            $display("FAIL reset_width got %0d exp %0d", rst_lo, (30 - BRK) + HOLD);
        else n_pass++;
        n_checks++;
        if (gp_lo != (bsel ? (30 - BRK) + HOLD + STRAP : 0))
            $display("FAIL gpio0_width got %0d exp %0d", gp_lo,
                     bsel ? (30 - BRK) + HOLD + STRAP : 0);
        else n_pass++;
        n_checks++;
        if (seq_hi != (30 - BRK) + HOLD + STRAP)
            $display("FAIL led_rst_width got %0d exp %0d", seq_hi, (30 - BRK) + HOLD + STRAP);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        boot_sel = 1'($urandom_range(0, 1));
        host_rxd = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL async_pre cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
        end
        // Mid-HOLD, well away from any clock edge.
        rst = 1'b1;
        #1;
        n_checks++;
        if ({esp_reset_n, led_rst, esp_gpio0} !== 3'b101)
            $display("FAIL async_release got %b exp %b",
                     {esp_reset_n, led_rst, esp_gpio0}, 3'b101);
        else n_pass++;
        host_rxd = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            host_rxd = !(i >= 6 && i < 10);
            tick();
            n_checks++;
            if (dut_vec() !== exp_v)
                $display("FAIL async_post cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int h_left = 0;
        int e_left = 0;
        int errs   = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (h_left == 0) begin
                if ($urandom_range(0, 19) == 0) begin
                    host_rxd = 1'b0;
                    h_left   = int'($urandom_range(15, 40));
                end else begin
                    host_rxd = 1'($urandom_range(0, 1));
                    h_left   = int'($urandom_range(1, 6));
                end
            end
            h_left--;
            if (e_left == 0) begin
                esp_rxd = 1'($urandom_range(0, 1));
                e_left  = int'($urandom_range(1, 12));
            end
            e_left--;
            if ($urandom_range(0, 7) == 0) boot_sel = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (dut_vec() !== exp_v) begin
                errs++;
                if (errs <= 20)
                    $display("FAIL random cyc %0d got %b exp %b", i, dut_vec(), exp_v);
            end else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_led_retrigger();
        test_short_break();
        test_boot(1'b1, 1'b1);
        test_boot(1'b0, 1'b0);
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bridge_ctl.md
Name: uart_bridge_ctl

Overview:
- Clocked, parametrised successor to the combinational FTDI-channel-B to ESP8266 UART pass-through.
- Forwards UART lines in both directions through metastability synchronisers.
- Stretches line activity into visible LED pulses.
- Adds a break-triggered ESP8266 reset/boot-strap sequencer, so the host can reset the module into flash-run or bootloader mode over the serial line alone.
- Sits at top level between the FT2232H channel-B pins and the ESP8266 header.

Parameters:
- SYNC_STAGES, 2, flip-flop count in each input synchroniser; legal range 2..4.
- LED_STRETCH, 600000, activity LED on-time in clk cycles after the last falling edge (50 ms at 12 MHz).
- BREAK_CYCLES, 1200000, continuous low on synced host_rxd that counts as a break (100 ms).
- RESET_HOLD, 120000, cycles esp_reset_n stays low after the break ends (10 ms).
- STRAP_CYCLES, 1200000, cycles esp_gpio0 stays strapped after reset release (100 ms).

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  asynchronous, active-high reset.
- host_rxd  input  1  serial data from FTDI BDBUS0.
- host_txd  output  1  serial data to FTDI BDBUS1.
- esp_txd  output  1  serial data to ESP8266 RXD.
- esp_rxd  input  1  serial data from ESP8266 TXD.
- esp_reset_n  output  1  ESP8266 reset, active low.
- esp_gpio0  output  1  ESP8266 GPIO0 boot strap; 1 = run from flash, 0 = bootloader.
- boot_sel  input  1  boot mode request, sampled at break detection; 1 = bootloader.
- led_tx  output  1  host-to-ESP activity, active high.
- led_rx  output  1  ESP-to-host activity, active high.
- led_rst  output  1  high while the reset sequence runs.

Behaviour:
- Reset values (async on rst, all counters zero, FSM in IDLE):
  - All synchroniser flops = 1 (line idle).
  - host_txd = 1, esp_txd = 1, esp_reset_n = 1, esp_gpio0 = 1.
  - led_tx = 0, led_rx = 0, led_rst = 0.
- Synchronisers:
  - host_rxd to h_s and esp_rxd to e_s, each SYNC_STAGES flops.
  - esp_txd and host_txd are registered, giving SYNC_STAGES+1 cycles input-to-output latency.
- Forwarding:
  - host_txd <= e_s always.
  - esp_txd <= h_s in IDLE and BREAK; forced 1 in HOLD and STRAP.
- Activity stretchers, one per direction:
  - Falling edge detected as previous synced sample 1 and current 0.
  - On a falling edge, counter <= LED_STRETCH; otherwise it decrements and saturates at 0.
  - LED = (counter != 0), registered.
  - A new edge while counting reloads the counter (retrigger).
  - Counter width is clog2(LED_STRETCH+1).
- FSM (states IDLE, BREAK, HOLD, STRAP):
  - IDLE: brk_cnt cleared while h_s = 1. When h_s = 0, go to BREAK with brk_cnt = 1.
  - BREAK: h_s = 1 returns to IDLE with no side effect; this covers normal start and data bits. Otherwise brk_cnt increments. When brk_cnt reaches BREAK_CYCLES, go to HOLD and latch boot_sel into mode.
  - HOLD: esp_reset_n = 0 and esp_gpio0 = ~mode. tmr is held at 0 while h_s = 0. After h_s returns to 1, tmr counts; at tmr = RESET_HOLD-1, go to STRAP.
  - STRAP: esp_reset_n = 1, esp_gpio0 = ~mode held; after STRAP_CYCLES cycles go to IDLE, and esp_gpio0 returns to 1.
  - A new low on h_s during STRAP is ignored; break detection restarts only in IDLE.
- led_rst = 1 exactly in HOLD and STRAP.
- All counters saturate and never wrap.
- Assertion of rst mid-sequence releases esp_reset_n immediately (async to 1) and aborts the sequence.
- boot_sel changes after the latch point have no effect until the next break.

Optional Feature:
- Macro: UART_BRIDGE_LOOPBACK_EN.
- When defined:
  - Extra input port loopback (1 bit), synchronised through SYNC_STAGES flops (reset 0).
  - While the synced loopback = 1: host_txd <= h_s, esp_txd forced 1, esp_rxd ignored, and led_rx mirrors host-side edges.
  - Break detection still runs.
- When undefined: the port is absent and behaviour is as above.

Test Plan:
All scenarios use SYNC_STAGES=2, LED_STRETCH=8, BREAK_CYCLES=20, RESET_HOLD=5, STRAP_CYCLES=10.
- Reset release, then toggle host_rxd 1->0 -> esp_txd falls exactly 3 clk later; led_tx = 1 for 8 cycles after the registered edge; host_txd stays 1.
- Two esp_rxd falling edges 5 cycles apart -> led_rx stays high continuously and drops 8 cycles after the second edge.
- host_rxd low 19 cycles, then high -> no HOLD; esp_reset_n stays 1; esp_txd follows the line.
- boot_sel = 1, host_rxd low 30 cycles -> HOLD entered at synced-low cycle 20 with esp_reset_n = 0, esp_gpio0 = 0, esp_txd = 1, led_rst = 1. Line high -> reset released 5 cycles later. esp_gpio0 = 0 for 10 more cycles, then 1.
- Repeat with boot_sel = 0 -> esp_gpio0 stays 1 throughout. Toggle boot_sel during HOLD -> no change.
- Assert rst during HOLD -> esp_reset_n = 1 and led_rst = 0 without a clock edge; FSM in IDLE after release.
